// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between fetch
// and load/store, with registered outputs and a timeout watchdog.
//
// Ports:
//   clk, rst                       clock, sync active-high reset
//   if_req/if_addr                 fetch request (held until if_gnt)
//   if_gnt/if_valid/if_rdata       fetch grant, completion, instruction
//   ls_req/ls_we/ls_addr           load/store request (held until ls_gnt)
//   ls_wdata/ls_be                 store data and byte enables
//   ls_gnt/ls_valid/ls_rdata       load/store grant, completion, load data
//   err                            one-cycle pulse on watchdog abort
//   mem_req/mem_we/mem_addr        memory port request, held per transaction
//   mem_wdata/mem_be               memory write data and byte enables
//   mem_ready/mem_rdata            memory completion and read data
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_gnt,
    output logic                ls_valid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        LS_BUSY
    } state_t;

    state_t           state_q, state_d;
    // rr_q: 1 = load/store was granted last, 0 = fetch
    logic             rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic              if_gnt_d, ls_gnt_d;
    logic              if_valid_d, ls_valid_d;
    logic              err_d, mem_req_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic [BE_W-1:0]   mem_be_d;
    logic [DATA_W-1:0] if_rdata_d, ls_rdata_d;

    logic pick_if, pick_ls, busy, expire;

    // On a tie, grant whichever port did not win last time.
    assign pick_if = if_req & (~ls_req | rr_q);
    assign pick_ls = ls_req & ~pick_if;
    assign busy    = (state_q != IDLE);
    assign expire  = busy & ~mem_ready & (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= 1'b1;
            cnt_q     <= '0;
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_valid  <= 1'b0;
            ls_valid  <= 1'b0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            if_gnt    <= if_gnt_d;
            ls_gnt    <= ls_gnt_d;
            if_valid  <= if_valid_d;
            ls_valid  <= ls_valid_d;
            err       <= err_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_be    <= mem_be_d;
            if_rdata  <= if_rdata_d;
            ls_rdata  <= ls_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pick_if)
                    state_d = IF_BUSY;
                else if (pick_ls)
                    state_d = LS_BUSY;
            end
            IF_BUSY, LS_BUSY: begin
                if (mem_ready || expire)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        if_gnt_d    = 1'b0;
        ls_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        ls_valid_d  = 1'b0;
        err_d       = 1'b0;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_be_d    = mem_be;
        if_rdata_d  = if_rdata;
        ls_rdata_d  = ls_rdata;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_if) begin
                    rr_d       = 1'b0;
                    if_gnt_d   = 1'b1;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    mem_be_d   = {BE_W{1'b1}};
                end else if (pick_ls) begin
                    rr_d        = 1'b1;
                    ls_gnt_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ls_we;
                    mem_addr_d  = ls_addr;
                    mem_wdata_d = ls_wdata;
                    mem_be_d    = ls_be;
                end
            end
            IF_BUSY, LS_BUSY: begin
                if (mem_ready) begin
                    cnt_d     = '0;
                    mem_req_d = 1'b0;
                    if (state_q == IF_BUSY) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        ls_valid_d = 1'b1;
                        if (!mem_we)
                            ls_rdata_d = mem_rdata;
                    end
                end else if (expire) begin
                    cnt_d     = '0;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter; the bench plays the
// memory and both requesters and checks against hand-computed values.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_valid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt, ls_valid;
    logic [31:0] ls_rdata;
    logic        err, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_be    (ls_be),
        .ls_gnt   (ls_gnt),
        .ls_valid (ls_valid),
        .ls_rdata (ls_rdata),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " if_gnt"},   64'(if_gnt),    0);
        check({tag, " ls_gnt"},   64'(ls_gnt),    0);
        check({tag, " if_valid"}, 64'(if_valid),  0);
        check({tag, " ls_valid"}, 64'(ls_valid),  0);
        check({tag, " err"},      64'(err),       0);
        check({tag, " mem_req"},  64'(mem_req),   0);
        check({tag, " mem_we"},   64'(mem_we),    0);
        check({tag, " mem_addr"}, 64'(mem_addr),  0);
        check({tag, " mem_wd"},   64'(mem_wdata), 0);
        check({tag, " mem_be"},   64'(mem_be),    0);
        check({tag, " if_rdata"}, 64'(if_rdata),  0);
        check({tag, " ls_rdata"}, 64'(ls_rdata),  0);
    endtask

    initial begin
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        ls_req    = 1'b0;
        ls_we     = 1'b0;
        ls_addr   = '0;
        ls_wdata  = '0;
        ls_be     = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
        check_idle_zero("reset");

        // single fetch, zero wait states
        if_req  = 1'b1;
        if_addr = 32'h10;
        tick();
        check("f1 if_gnt",  64'(if_gnt),   1);
        check("f1 mem_req", 64'(mem_req),  1);
        check("f1 addr",    64'(mem_addr), 32'h10);
        check("f1 we",      64'(mem_we),   0);
        check("f1 be",      64'(mem_be),   4'hF);
        if_req    = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h0050_0093;
        tick();
        mem_ready = 1'b0;
        check("f1 valid",   64'(if_valid), 1);
        check("f1 rdata",   64'(if_rdata), 32'h0050_0093);
        check("f1 gnt off", 64'(if_gnt),   0);
        check("f1 req off", 64'(mem_req),  0);
        tick();
        check("f1 valid off", 64'(if_valid), 0);

        // store with 2 wait states
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h100;
        ls_wdata = 32'hDEAD_BEEF;
        ls_be    = 4'b0011;
        tick();
        check("st gnt",  64'(ls_gnt),    1);
        check("st we",   64'(mem_we),    1);
        check("st addr", 64'(mem_addr),  32'h100);
        ls_req   = 1'b0;
        ls_wdata = 32'h0BAD_0BAD;
        ls_be    = 4'hF;
        for (int i = 0; i < 3; i++) begin
            check("st req",   64'(mem_req),   1);
            check("st wdata", 64'(mem_wdata), 32'hDEAD_BEEF);
            check("st be",    64'(mem_be),    4'b0011);
            check("st valid", 64'(ls_valid),  0);
            if (i == 2) begin
                mem_ready = 1'b1;
                mem_rdata = 32'h1234_5678;
            end
            tick();
        end
        mem_ready = 1'b0;
        check("st valid1", 64'(ls_valid), 1);
        check("st rdata",  64'(ls_rdata), 0);
        check("st reqoff", 64'(mem_req),  0);
        tick();
        check("st valid0", 64'(ls_valid), 0);

        // contention: both held, expect IF, LS, IF, LS
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h50;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h60;
        ls_be   = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr if_gnt", 64'(if_gnt), 64'(k % 2 == 0));
            check("rr ls_gnt", 64'(ls_gnt), 64'(k % 2 == 1));
            check("rr addr", 64'(mem_addr),
                  (k % 2 == 0) ? 64'h50 : 64'h60);
            mem_ready = 1'b1;
            mem_rdata = 32'hC000_0000 + 32'(k);
            tick();
            mem_ready = 1'b0;
            check("rr if_valid", 64'(if_valid), 64'(k % 2 == 0));
            check("rr ls_valid", 64'(ls_valid), 64'(k % 2 == 1));
            if (k % 2 == 0)
                check("rr if_rdata", 64'(if_rdata),
                      64'(32'hC000_0000 + 32'(k)));
            else
                check("rr ls_rdata", 64'(ls_rdata),
                      64'(32'hC000_0000 + 32'(k)));
        end
        if_req = 1'b0;
        ls_req = 1'b0;

        // timeout on a load that never completes
        tick();
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h200;
        tick();
        check("to gnt",  64'(ls_gnt),   1);
        check("to addr", 64'(mem_addr), 32'h200);
        ls_req = 1'b0;
        for (int i = 2; i <= 15; i++) begin
            tick();
            check("to busy req", 64'(mem_req), 1);
            check("to busy err", 64'(err),     0);
        end
        tick();
        check("to err",     64'(err),      1);
        check("to req off", 64'(mem_req),  0);
        check("to novalid", 64'(ls_valid), 0);
        check("to rdata",   64'(ls_rdata), 32'hC000_0003);
        if_req  = 1'b1;
        if_addr = 32'h20;
        tick();
        check("to err off", 64'(err),      0);
        check("to f gnt",   64'(if_gnt),   1);
        check("to f addr",  64'(mem_addr), 32'h20);
        if_req    = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h11;
        tick();
        mem_ready = 1'b0;
        check("to f valid", 64'(if_valid), 1);
        check("to f rdata", 64'(if_rdata), 32'h11);

        // reset during the second busy cycle of a fetch
        tick();
        if_req  = 1'b1;
        if_addr = 32'h30;
        tick();
        check("rm gnt", 64'(if_gnt), 1);
        if_req = 1'b0;
        tick();
        check("rm busy2", 64'(mem_req), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_zero("rm");
        mem_ready = 1'b1;
        mem_rdata = 32'h77;
        tick();
        mem_ready = 1'b0;
        check("rm late valid", 64'(if_valid), 0);
        check("rm late req",   64'(mem_req),  0);
        check("rm late rdata", 64'(if_rdata), 0);

        // back-to-back fetches, valid every 2 cycles
        if_req  = 1'b1;
        if_addr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bb gnt",   64'(if_gnt),   1);
            check("bb nval",  64'(if_valid), 0);
            check("bb addr",  64'(mem_addr),
                  64'(32'h40 + 32'(4 * i)));
            if_addr   = 32'h44 + 32'(4 * i);
            mem_ready = 1'b1;
            mem_rdata = 32'hA0 + 32'(i);
            tick();
            mem_ready = 1'b0;
            check("bb valid", 64'(if_valid), 1);
            check("bb ngnt",  64'(if_gnt),   0);
            check("bb rdata", 64'(if_rdata),
                  64'(32'hA0 + 32'(i)));
        end
        if_req = 1'b0;
        tick();
        check("bb end", 64'(if_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
